mem_wb_pipe: RTL and testbench

//  Parametrised MEM->WB pipeline register for the multi-issue core: NUM_WR regfile write channels plus HI/LO.

---
 rtl/mem_wb_pipe_pkg.sv | 37 +++
 rtl/pipe_sat_cnt.sv | 26 ++
 rtl/mem_wb_pipe.sv | 120 ++++++++++++
 tb/tb_mem_wb_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants, the stage-action type and the stall/flush decode for the
// MEM->WB pipeline register and its saturating counters.
package mem_wb_pipe_pkg;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam int   PIPE_CNT_W    = 32;

    // Counter bus (31:0) and its saturation value
    typedef logic [PIPE_CNT_W-1:0] pipe_cnt_t;
    localparam pipe_cnt_t CNT_MAX = {PIPE_CNT_W{1'b1}};

    // What the register does on the coming edge
    typedef enum logic [1:0] {
        ACT_BUBBLE  = 2'd0,
        ACT_ADVANCE = 2'd1,
        ACT_HOLD    = 2'd2
    } pipe_act_e;

    // Flush beats everything; a stalled stage whose consumer runs emits a bubble
    function automatic pipe_act_e pipe_action(input logic flush,
                                              input logic stall_cur,
                                              input logic stall_down);
        if (flush)
            return ACT_BUBBLE;
        else if (stall_cur == STOP && stall_down == NO_STOP)
            return ACT_BUBBLE;
        else if (stall_cur == NO_STOP)
            return ACT_ADVANCE;
        else
            return ACT_HOLD;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
import mem_wb_pipe_pkg::*;

module pipe_sat_cnt (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      inc,
    output pipe_cnt_t count
);

    pipe_cnt_t count_reg;

    // Count events, clear on request, never roll over
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_reg <= '0;
        else if (clr)
            count_reg <= '0;
        else if (inc && count_reg != CNT_MAX)
            count_reg <= count_reg + 1'b1;
    end

    assign count = count_reg;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: NUM_WR regfile write channels plus HI/LO,
// with valid bit, flush, stall handling and same-address write squashing.
// Optional macro PIPE_PERF_EN adds hold-cycle and bubble counters.
import mem_wb_pipe_pkg::*;

module mem_wb_pipe #(
    parameter int NUM_WR  = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     mem_valid,
    input  logic [NUM_WR*ADDR_W-1:0] mem_wd,
    input  logic [NUM_WR-1:0]        mem_wreg,
    input  logic [NUM_WR*DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0]        mem_hi,
    input  logic [DATA_W-1:0]        mem_lo,
    input  logic                     mem_whilo,
    output logic                     wb_valid,
    output logic [NUM_WR*ADDR_W-1:0] wb_wd,
    output logic [NUM_WR-1:0]        wb_wreg,
    output logic [NUM_WR*DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo,
    output logic                     wb_whilo
`ifdef PIPE_PERF_EN
    ,
    output pipe_cnt_t                wb_stall_cnt,
    output pipe_cnt_t                wb_bubble_cnt
`endif
);

    pipe_act_e                     act;
    logic [NUM_WR-1:0][NUM_WR-1:0] pair_hit;
    logic [NUM_WR-1:0]             squash;
    logic [NUM_WR-1:0]             wreg_next;
    logic                          whilo_next;

    // pair_hit[i][j]: a later channel j writes the same register as channel i
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_row
            for (gj = 0; gj < NUM_WR; gj++) begin : g_col
                if (gj > gi) begin : g_cmp
                    assign pair_hit[gi][gj] = mem_wreg[gi] && mem_wreg[gj] &&
                        (mem_wd[gi*ADDR_W +: ADDR_W] == mem_wd[gj*ADDR_W +: ADDR_W]);
                end else begin : g_none
                    assign pair_hit[gi][gj] = 1'b0;
                end
            end
            assign squash[gi] = |pair_hit[gi];
        end
    endgenerate

    // Decode this edge's action and the enables that will be captured
    always_comb begin
        act        = pipe_action(flush, stall[STAGE], stall[STAGE+1]);
        wreg_next  = mem_valid ? (mem_wreg & ~squash) : '0;
        whilo_next = mem_valid ? mem_whilo : WRITE_DISABLE;
    end

    // Pipeline register: bubble, advance or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            wb_valid <= 1'b0;
            wb_wd    <= '0;
            wb_wreg  <= '0;
            wb_wdata <= '0;
            wb_hi    <= '0;
            wb_lo    <= '0;
            wb_whilo <= WRITE_DISABLE;
        end else begin
            case (act)
                ACT_BUBBLE: begin
                    wb_valid <= 1'b0;
                    wb_wd    <= '0;
                    wb_wreg  <= '0;
                    wb_wdata <= '0;
                    wb_hi    <= '0;
                    wb_lo    <= '0;
                    wb_whilo <= WRITE_DISABLE;
                end
                ACT_ADVANCE: begin
                    wb_valid <= mem_valid;
                    wb_wd    <= mem_wd;
                    wb_wreg  <= wreg_next;
                    wb_wdata <= mem_wdata;
                    wb_hi    <= mem_hi;
                    wb_lo    <= mem_lo;
                    wb_whilo <= whilo_next;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    pipe_sat_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (act == ACT_HOLD),
        .count (wb_stall_cnt)
    );

    pipe_sat_cnt u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (act == ACT_BUBBLE),
        .count (wb_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed steps followed by random
// traffic, all compared against a behavioural model of the stage rules.
// Counter checks are compiled only when PIPE_PERF_EN is defined.
module tb_mem_wb_pipe;

    localparam int NUM_WR  = 2;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int STALL_W = 6;
    localparam int STAGE   = 4;

    logic                     clk = 1'b0;
    logic                     clk_en = 1'b0;
    logic                     rst = 1'b0;
    logic [STALL_W-1:0]       stall = '0;
    logic                     flush = 1'b0;
    logic                     mem_valid = 1'b0;
    logic [NUM_WR*ADDR_W-1:0] mem_wd = '0;
    logic [NUM_WR-1:0]        mem_wreg = '0;
    logic [NUM_WR*DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0]        mem_hi = '0;
    logic [DATA_W-1:0]        mem_lo = '0;
    logic                     mem_whilo = 1'b0;
    logic                     wb_valid;
    logic [NUM_WR*ADDR_W-1:0] wb_wd;
    logic [NUM_WR-1:0]        wb_wreg;
    logic [NUM_WR*DATA_W-1:0] wb_wdata;
    logic [DATA_W-1:0]        wb_hi;
    logic [DATA_W-1:0]        wb_lo;
    logic                     wb_whilo;
`ifdef PIPE_PERF_EN
    logic [31:0]              wb_stall_cnt;
    logic [31:0]              wb_bubble_cnt;
`endif

    // Reference state
    logic                     e_valid;
    logic [NUM_WR*ADDR_W-1:0] e_wd;
    logic [NUM_WR-1:0]        e_wreg;
    logic [NUM_WR*DATA_W-1:0] e_wdata;
    logic [DATA_W-1:0]        e_hi;
    logic [DATA_W-1:0]        e_lo;
    logic                     e_whilo;
    logic [31:0]              e_stall_cnt;
    logic [31:0]              e_bubble_cnt;

    int errors = 0;
    int checks = 0;

    mem_wb_pipe #(
        .NUM_WR (NUM_WR), .DATA_W (DATA_W), .ADDR_W (ADDR_W),
        .STALL_W(STALL_W), .STAGE (STAGE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .mem_valid (mem_valid),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
        .mem_whilo (mem_whilo),
        .wb_valid  (wb_valid),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .wb_hi     (wb_hi),
        .wb_lo     (wb_lo),
        .wb_whilo  (wb_whilo)
`ifdef PIPE_PERF_EN
        ,
        .wb_stall_cnt  (wb_stall_cnt),
        .wb_bubble_cnt (wb_bubble_cnt)
`endif
    );

    // Gated clock so the reset check can run with the clock stopped
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 128'(wb_valid), 128'(e_valid));
        check({tag, ".wd"},    128'(wb_wd),    128'(e_wd));
        check({tag, ".wreg"},  128'(wb_wreg),  128'(e_wreg));
        check({tag, ".wdata"}, 128'(wb_wdata), 128'(e_wdata));
        check({tag, ".hi"},    128'(wb_hi),    128'(e_hi));
        check({tag, ".lo"},    128'(wb_lo),    128'(e_lo));
        check({tag, ".whilo"}, 128'(wb_whilo), 128'(e_whilo));
`ifdef PIPE_PERF_EN
        check({tag, ".stall_cnt"},  128'(wb_stall_cnt),  128'(e_stall_cnt));
        check({tag, ".bubble_cnt"}, 128'(wb_bubble_cnt), 128'(e_bubble_cnt));
`endif
        $display("step %-12s stall=%b flush=%b valid=%b wd=%h wreg=%b whilo=%b",
                 tag, stall, flush, wb_valid, wb_wd, wb_wreg, wb_whilo);
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        e_valid = 0; e_wd = '0; e_wreg = '0; e_wdata = '0;
        e_hi = '0; e_lo = '0; e_whilo = 0;
        e_stall_cnt = '0; e_bubble_cnt = '0;
    endtask

    // What one clock edge should do given the inputs currently applied
    task automatic model_edge();
        logic cur, down, w;
        cur  = stall[STAGE];
        down = stall[STAGE+1];
        if (flush || (cur && !down)) begin
            e_valid = 0; e_wd = '0; e_wreg = '0; e_wdata = '0;
            e_hi = '0; e_lo = '0; e_whilo = 0;
            e_bubble_cnt = sat_inc(e_bubble_cnt);
        end else if (!cur) begin
            e_valid = mem_valid;
            e_wd    = mem_wd;
            e_wdata = mem_wdata;
            e_hi    = mem_hi;
            e_lo    = mem_lo;
            e_whilo = mem_valid && mem_whilo;
            for (int i = 0; i < NUM_WR; i++) begin
                w = mem_valid && mem_wreg[i];
                for (int j = i + 1; j < NUM_WR; j++)
                    if (mem_wreg[j] && mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])
                        w = 0;
                e_wreg[i] = w;
            end
        end else begin
            e_stall_cnt = sat_inc(e_stall_cnt);
        end
    endtask

    // Apply the model for the coming edge, clock it, sample just after
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic random_inputs();
        mem_valid = 1'($urandom_range(0, 3) != 0);
        for (int i = 0; i < NUM_WR; i++)
            mem_wd[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
        mem_wreg  = NUM_WR'($urandom);
        for (int i = 0; i < NUM_WR; i++)
            mem_wdata[i*DATA_W +: DATA_W] = $urandom;
        mem_hi    = $urandom;
        mem_lo    = $urandom;
        mem_whilo = 1'($urandom);
    endtask

    initial begin
        // 1: reset with random inputs and no clock
        random_inputs();
        stall = 6'($urandom);
        flush = 1'($urandom);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stall = '0; flush = 0;

        // 2: advance one instruction
        mem_valid = 1; mem_wreg = 2'b01; mem_whilo = 1;
        mem_wd = {5'd0, 5'd5};
        mem_wdata = {32'h0, 32'hDEAD_BEEF};
        mem_hi = 32'd1; mem_lo = 32'd2;
        step("advance");
        check("advance.wd0", 128'(wb_wd[4:0]), 128'd5);
        check("advance.wdata0", 128'(wb_wdata[31:0]), 128'hDEAD_BEEF);

        // 3: hold three edges, then a stall bubble
        random_inputs();
        stall = 6'b110000;
        for (int k = 0; k < 3; k++) step("hold");
        check("hold.wdata0", 128'(wb_wdata[31:0]), 128'hDEAD_BEEF);
`ifdef PIPE_PERF_EN
        check("hold.stall_cnt3", 128'(wb_stall_cnt), 128'd3);
`endif
        stall = 6'b010000;
        step("bubble");
        check("bubble.valid", 128'(wb_valid), 128'd0);
`ifdef PIPE_PERF_EN
        check("bubble.cnt1", 128'(wb_bubble_cnt), 128'd1);
`endif

        // 4: flush overrides hold
        stall = '0; random_inputs(); mem_valid = 1;
        step("refill");
        stall = 6'b110000; flush = 1;
        step("flush");
        check("flush.valid", 128'(wb_valid), 128'd0);
        flush = 0;

        // 5: same-address squash, then distinct addresses
        stall = '0; mem_valid = 1; mem_wreg = 2'b11;
        mem_wd = {5'd7, 5'd7};
        step("waw_same");
        check("waw_same.wreg", 128'(wb_wreg), 128'b10);
        mem_wd = {5'd8, 5'd7};
        step("waw_diff");
        check("waw_diff.wreg", 128'(wb_wreg), 128'b11);

        // 6: invalid instruction drops its write enables
        mem_valid = 0; mem_wreg = 2'b11; mem_whilo = 1;
        step("invalid");
        check("invalid.wreg", 128'(wb_wreg), 128'b00);

        // r0 destination passes through unchanged
        mem_valid = 1; mem_wd = {5'd3, 5'd0}; mem_wreg = 2'b11;
        step("r0_write");

        // Reset in the middle of a hold wins immediately
        stall = 6'b110000;
        step("pre_rst_hold");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst");

`ifdef PIPE_PERF_EN
        // Saturation: preload near the top, three holds must stick at max
        stall = 6'b110000;
        dut.u_stall_cnt.count_reg = 32'hFFFF_FFFE;
        e_stall_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) step("sat");
        check("sat.max", 128'(wb_stall_cnt), 128'hFFFF_FFFF);
`endif

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            random_inputs();
            case ($urandom_range(0, 4))
                0, 1:    stall = '0;
                2:       stall = 6'b010000;
                3:       stall = 6'b110000;
                default: stall = 6'($urandom);
            endcase
            flush = 1'($urandom_range(0, 9) == 0);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
